vpu_linebuf_sched: RTL and testbench

VPU_LINEBUF_SCHED -- requirements
Module: vpu_linebuf_sched

---
 rtl/vpu_linebuf_sched_if.sv | 37 +++
 rtl/vpu_linebuf_sched.sv | 129 ++++++++++++
 tb/tb_vpu_linebuf_sched.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vpu_linebuf_sched_if.sv
// Port bundle for the line buffer scheduler: line timing, sprite writer access and line buffer port B.
// The scheduler takes the slave view; the master view drives timing, requests and port B read data.
interface vpu_linebuf_sched_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              line_start;
   logic              active_line;
   logic              sp_req;
   logic              sp_we;
   logic [ADDR_W-1:0] sp_addr;
   logic [DATA_W-1:0] sp_wdata;
   logic              sp_gnt;
   logic [DATA_W-1:0] sp_rdata;
   logic              sp_rvalid;
   logic              line_init;
   logic              line_bankb;
   logic              line_web;
   logic [ADDR_W-1:0] line_addrb;
   logic [DATA_W-1:0] line_dinb;
   logic [DATA_W-1:0] line_doutb;
   logic              clr_busy;
   logic              overrun;
   logic [15:0]       ovr_cnt;

   modport slave (
      input  line_start, active_line, sp_req, sp_we, sp_addr, sp_wdata, line_doutb,
      output sp_gnt, sp_rdata, sp_rvalid, line_init, line_bankb, line_web,
             line_addrb, line_dinb, clr_busy, overrun, ovr_cnt
   );

   modport master (
      output line_start, active_line, sp_req, sp_we, sp_addr, sp_wdata, line_doutb,
      input  sp_gnt, sp_rdata, sp_rvalid, line_init, line_bankb, line_web,
             line_addrb, line_dinb, clr_busy, overrun, ovr_cnt
   );
endinterface

// File: rtl/vpu_linebuf_sched.sv
// Line buffer port B scheduler: clears the freshly swapped bank each visible line, then serves the sprite writer.
// Optional macro VPU_LINESCHED_STATS_EN builds a saturating overrun counter on ovr_cnt.
module vpu_linebuf_sched #(
   parameter int               ADDR_W   = 9,
   parameter int               DATA_W   = 32,
   parameter int               SCREEN_W = 320,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input logic              clk,
   input logic              rst,
   vpu_linebuf_sched_if.slave bus
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, RENDER} state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic              w_go;
   logic              w_gnt;
   logic              w_clrLast;
   logic              w_webNext;
   logic              w_initNext;
   logic              w_busyNext;
   logic [ADDR_W-1:0] w_addrNext;
   logic [DATA_W-1:0] w_dinNext;
   logic              r_bankb;
   logic              r_init;
   logic              r_web;
   logic [ADDR_W-1:0] r_addrb;
   logic [DATA_W-1:0] r_dinb;
   logic              r_clrBusy;
   logic              r_overrun;
   logic              r_rdPend;
   logic              r_rvalid;

   assign w_go      = bus.line_start & bus.active_line;
   assign w_clrLast = (r_state == CLEAR) && (r_addrb == LAST_ADDR);
   assign w_gnt     = bus.sp_req & (r_state == RENDER) & ~bus.line_start;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      if (bus.line_start)  w_stateNext = w_go ? CLEAR : IDLE;
      else if (w_clrLast)  w_stateNext = RENDER;
   end

   // While clearing, the port B address register doubles as the clear counter.
   always_comb begin
      w_webNext  = 1'b0;
      w_initNext = 1'b0;
      w_busyNext = 1'b0;
      w_addrNext = r_addrb;
      w_dinNext  = r_dinb;
      if (w_go) begin
         w_webNext  = 1'b1;
         w_initNext = 1'b1;
         w_busyNext = 1'b1;
         w_addrNext = '0;
         w_dinNext  = CLR_VAL;
      end else if (bus.line_start) begin
         w_webNext = 1'b0;
      end else if ((r_state == CLEAR) && !w_clrLast) begin
         w_webNext  = 1'b1;
         w_busyNext = 1'b1;
         w_addrNext = r_addrb + 1'b1;
         w_dinNext  = CLR_VAL;
      end else if (w_gnt) begin
         w_webNext  = bus.sp_we;
         w_addrNext = bus.sp_addr;
         w_dinNext  = bus.sp_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bankb   <= 1'b0;
         r_init    <= 1'b0;
         r_web     <= 1'b0;
         r_addrb   <= '0;
         r_dinb    <= '0;
         r_clrBusy <= 1'b0;
         r_overrun <= 1'b0;
         r_rdPend  <= 1'b0;
         r_rvalid  <= 1'b0;
      end else begin
         r_init    <= w_initNext;
         r_web     <= w_webNext;
         r_addrb   <= w_addrNext;
         r_dinb    <= w_dinNext;
         r_clrBusy <= w_busyNext;
         r_rdPend  <= w_gnt & ~bus.sp_we;
         r_rvalid  <= r_rdPend;
         if (w_go) r_bankb <= ~r_bankb;
         if (bus.line_start && (r_state == CLEAR)) r_overrun <= 1'b1;
      end
   end

`ifdef VPU_LINESCHED_STATS_EN
   logic [15:0] r_ovrCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovrCnt <= '0;
      end else if (bus.line_start && (r_state == CLEAR) && (r_ovrCnt != 16'hFFFF)) begin
         r_ovrCnt <= r_ovrCnt + 16'd1;
      end
   end

   assign bus.ovr_cnt = r_ovrCnt;
`else
   assign bus.ovr_cnt = 16'd0;
`endif

   assign bus.sp_gnt     = w_gnt;
   assign bus.sp_rdata   = bus.line_doutb;
   assign bus.sp_rvalid  = r_rvalid;
   assign bus.line_init  = r_init;
   assign bus.line_bankb = r_bankb;
   assign bus.line_web   = r_web;
   assign bus.line_addrb = r_addrb;
   assign bus.line_dinb  = r_dinb;
   assign bus.clr_busy   = r_clrBusy;
   assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_vpu_linebuf_sched.sv
// Scoreboard bench for vpu_linebuf_sched: a line-level reference model queues expected port B traffic,
// read returns and per-cycle status; an independent monitor pops and compares what the DUT presents.
module tb_vpu_linebuf_sched;
   localparam int          ADDR_W   = 9;
   localparam int          DATA_W   = 32;
   localparam int          SCREEN_W = 320;
   localparam logic [31:0] CLR_VAL  = 32'h0BAD_F00D;

   typedef enum int {M_IDLE, M_CLEAR, M_RENDER} mode_t;

   typedef struct {
      int          cyc;
      logic [8:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } rd_t;

   typedef struct {
      int          cyc;
      logic        gnt;
      logic        bank;
      logic        init;
      logic        busy;
      logic        ovr;
      logic [15:0] cnt;
      logic        zeroBus;
   } st_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   wr_t wrQ[$];
   rd_t rdQ[$];
   st_t stQ[$];

   bit          modelOn = 1'b0;
   bit          started = 1'b0;
   int          lastStart = 0;
   bit          lastActive = 1'b0;
   bit          mBank = 1'b0;
   bit          mInit = 1'b0;
   bit          mOvr = 1'b0;
   bit          mZero = 1'b1;
   logic [15:0] mCnt = 16'd0;

   vpu_linebuf_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   vpu_linebuf_sched #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .SCREEN_W(SCREEN_W),
      .CLR_VAL(CLR_VAL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] memWord(input logic [8:0] a);
      return {a[7:0] ^ 8'hC3, 7'h00, a, 8'h5A};
   endfunction

   // Port B RAM stand-in: registered read whose contents are a fixed function of the address.
   always @(posedge clk) bus.line_doutb <= memWord(bus.line_addrb);

   // Where the line is, measured from the most recent line boundary.
   function automatic mode_t modeAt(input int t);
      if (!started || !lastActive) return M_IDLE;
      if (t <= lastStart + SCREEN_W) return M_CLEAR;
      return M_RENDER;
   endfunction

   task automatic applyStimulus(input bit ls, input bit act, input bit req, input bit we,
                                input logic [8:0] addr, input logic [31:0] wd, input bit r,
                                output logic g);
      st_t   s;
      wr_t   w;
      rd_t   rd;
      mode_t m;
      rst             = r;
      bus.line_start  = ls;
      bus.active_line = act;
      bus.sp_req      = req;
      bus.sp_we       = we;
      bus.sp_addr     = addr;
      bus.sp_wdata    = wd;
      m = modeAt(cyc);
      g = req && (m == M_RENDER) && !ls;
      s.cyc = cyc; s.gnt = g; s.bank = mBank; s.init = mInit; s.busy = (m == M_CLEAR);
      s.ovr = mOvr; s.cnt = mCnt; s.zeroBus = mZero;
      stQ.push_back(s);
      mInit = 1'b0;
      mZero = 1'b0;
      if (r) begin
         started = 1'b0; mBank = 1'b0; mOvr = 1'b0; mCnt = 16'd0; mZero = 1'b1;
         while (wrQ.size() > 0 && wrQ[$].cyc > cyc) void'(wrQ.pop_back());
         while (rdQ.size() > 0 && rdQ[$].cyc > cyc) void'(rdQ.pop_back());
      end else begin
         if (g && we) begin
            w.cyc = cyc + 1; w.addr = addr; w.data = wd;
            wrQ.push_back(w);
         end else if (g) begin
            rd.cyc = cyc + 2; rd.data = memWord(addr);
            rdQ.push_back(rd);
         end
         if (ls) begin
            if (m == M_CLEAR) begin
               mOvr = 1'b1;
`ifdef VPU_LINESCHED_STATS_EN
               if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
`endif
            end
            while (wrQ.size() > 0 && wrQ[$].cyc > cyc) void'(wrQ.pop_back());
            started = 1'b1; lastStart = cyc; lastActive = act;
            if (act) begin
               mBank = ~mBank;
               mInit = 1'b1;
               for (int i = 0; i < SCREEN_W; i++) begin
                  w.cyc = cyc + 1 + i; w.addr = 9'(i); w.data = CLR_VAL;
                  wrQ.push_back(w);
               end
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      logic g;
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 9'd0, 32'd0, 0, g);
   endtask

   task automatic checkOutput();
      st_t e;
      wr_t w;
      rd_t rd;
      if (stQ.size() > 0) begin
         e = stQ.pop_front();
         checks++;
         if (e.cyc != cyc || bus.sp_gnt !== e.gnt || bus.line_bankb !== e.bank || bus.line_init !== e.init ||
             bus.clr_busy !== e.busy || bus.overrun !== e.ovr || bus.ovr_cnt !== e.cnt) begin
            failures++;
            $display("[TB] FAIL status cyc=%0d got gnt=%b bank=%b init=%b busy=%b ovr=%b cnt=%0d expected gnt=%b bank=%b init=%b busy=%b ovr=%b cnt=%0d (tag %0d)",
                     cyc, bus.sp_gnt, bus.line_bankb, bus.line_init, bus.clr_busy, bus.overrun, bus.ovr_cnt,
                     e.gnt, e.bank, e.init, e.busy, e.ovr, e.cnt, e.cyc);
         end
         if (e.zeroBus) begin
            checks++;
            if (bus.line_web !== 1'b0 || bus.line_addrb !== 9'd0 || bus.line_dinb !== 32'd0 || bus.sp_rvalid !== 1'b0) begin
               failures++;
               $display("[TB] FAIL reset_bus cyc=%0d got web=%b addr=%0d din=%h rvalid=%b expected all zero",
                        cyc, bus.line_web, bus.line_addrb, bus.line_dinb, bus.sp_rvalid);
            end
         end
      end
      while (wrQ.size() > 0 && wrQ[0].cyc < cyc) begin
         w = wrQ.pop_front();
         checks++; failures++;
         $display("[TB] FAIL missed_write cyc=%0d expected addr=%0d data=%h at cyc %0d", cyc, w.addr, w.data, w.cyc);
      end
      if (wrQ.size() > 0 && wrQ[0].cyc == cyc) begin
         w = wrQ.pop_front();
         checks++;
         if (bus.line_web !== 1'b1 || bus.line_addrb !== w.addr || bus.line_dinb !== w.data) begin
            failures++;
            $display("[TB] FAIL write cyc=%0d got web=%b addr=%0d data=%h expected web=1 addr=%0d data=%h",
                     cyc, bus.line_web, bus.line_addrb, bus.line_dinb, w.addr, w.data);
         end
      end else if (bus.line_web !== 1'b0) begin
         checks++; failures++;
         $display("[TB] FAIL spurious_write cyc=%0d got web=%b addr=%0d expected web=0", cyc, bus.line_web, bus.line_addrb);
      end
      while (rdQ.size() > 0 && rdQ[0].cyc < cyc) begin
         rd = rdQ.pop_front();
         checks++; failures++;
         $display("[TB] FAIL missed_read cyc=%0d expected rvalid at cyc %0d", cyc, rd.cyc);
      end
      if (rdQ.size() > 0 && rdQ[0].cyc == cyc) begin
         rd = rdQ.pop_front();
         checks++;
         if (bus.sp_rvalid !== 1'b1 || bus.sp_rdata !== rd.data) begin
            failures++;
            $display("[TB] FAIL read cyc=%0d got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                     cyc, bus.sp_rvalid, bus.sp_rdata, rd.data);
         end
      end else if (bus.sp_rvalid !== 1'b0) begin
         checks++; failures++;
         $display("[TB] FAIL spurious_rvalid cyc=%0d got rvalid=%b expected 0", cyc, bus.sp_rvalid);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (modelOn) checkOutput();
      end
   end

   initial begin
      logic  g;
      int    n;
      mode_t m;
      bit    ls, act, r;
      rst = 1'b1;
      bus.line_start = 0; bus.active_line = 0; bus.sp_req = 0; bus.sp_we = 0;
      bus.sp_addr = '0; bus.sp_wdata = '0;
      @(negedge clk);
      modelOn = 1'b1;
      applyStimulus(0, 0, 0, 0, 9'd0, 32'd0, 1, g);
      applyStimulus(0, 0, 0, 0, 9'd0, 32'd0, 1, g);
      idle(3);

      // First visible line with a sprite write held across the clear.
      applyStimulus(1, 1, 0, 0, 9'd0, 32'd0, 0, g);
      g = 0; n = 0;
      while (!g && n < 1000) begin
         applyStimulus(0, 0, 1, 1, 9'd5, 32'hAABBCCDD, 0, g);
         n++;
      end
      if (!g) begin
         checks++; failures++;
         $display("[TB] FAIL grant_timeout got no grant after %0d cycles expected grant", n);
      end
      applyStimulus(0, 0, 1, 0, 9'd7, 32'd0, 0, g);
      idle(4);

      // Line boundary arriving at clear address 100.
      applyStimulus(1, 1, 0, 0, 9'd0, 32'd0, 0, g);
      idle(100);
      applyStimulus(1, 1, 0, 0, 9'd0, 32'd0, 0, g);
      idle(SCREEN_W + 5);

      // Blank line while rendering, with requests that must stay ungranted.
      applyStimulus(1, 0, 1, 1, 9'd3, 32'h12345678, 0, g);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, 9'd3, 32'h12345678, 0, g);
      idle(2);

      for (int i = 0; i < 6000; i++) begin
         m   = modeAt(cyc);
         ls  = ($urandom_range(0, 349) == 0);
         act = (m == M_CLEAR) ? 1'b1 : ($urandom_range(0, 3) != 0);
         r   = ($urandom_range(0, 2999) == 0);
         applyStimulus(ls, act, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       9'($urandom_range(0, SCREEN_W - 1)), $urandom, r, g);
      end

      // Reset in the middle of a clear.
      applyStimulus(1, 1, 0, 0, 9'd0, 32'd0, 0, g);
      idle(50);
      applyStimulus(0, 0, 0, 0, 9'd0, 32'd0, 1, g);
      idle(8);

      checks++;
      if (wrQ.size() != 0 || rdQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL leftover got writes=%0d reads=%0d pending expected 0", wrQ.size(), rdQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
